fetch_sequencer: RTL and testbench

Sequences instruction fetch from the byte-addressed 1 KB instruction ROM (8192-bit image, 32-bit little-endian words). It owns the program counter, issues one ROM read per cycle when buffer space allows, and stores returned words in a small FIFO. It presents those words to decode through a valid/ready handshake and handles redirects (branch/jump) and end-of-program detection. It sits between the instruction ROM read port and the decode stage.

---
 rtl/fetch_sequencer.sv | 170 +++++++++++++++++
 tb/tb_fetch_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Summary  : Owns the PC, issues one ROM word read per cycle into a small
//            instruction FIFO, hands words to decode, handles redirect/drain.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_pc,
    input  logic [ADDR_W-1:0] rom_size,
    output logic              rom_req,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    output logic              busy,
    output logic              fetch_done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]  C_DEPTH    = CNT_W'(DEPTH);
    localparam logic [ADDR_W:0]   C_WORD_EXT = {{(ADDR_W-2){1'b0}}, 3'd4};
    localparam logic [ADDR_W-1:0] C_WORD     = {{(ADDR_W-3){1'b0}}, 3'd4};
    localparam logic [ADDR_W-1:0] C_ALIGN    = {{(ADDR_W-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] req_pc_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [31:0]       data_mem_q [DEPTH];
    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
    logic              busy_q, done_q;

    logic [ADDR_W-1:0] w_start_pc, w_redir_pc, w_pc_inc;
    logic              w_space, w_flush, w_issue, w_push, w_pop;

    // Word at addr fits when addr+4 <= size; one extra bit keeps the sum from wrapping.
    function automatic logic in_range(input logic [ADDR_W-1:0] addr,
                                      input logic [ADDR_W-1:0] size);
        return ({1'b0, addr} + C_WORD_EXT) <= {1'b0, size};
    endfunction

    assign w_start_pc = start_pc & C_ALIGN;
    assign w_redir_pc = redirect_pc & C_ALIGN;
    assign w_pc_inc   = pc_q + C_WORD;
    assign w_space    = (count_q + CNT_W'(inflight_q)) < C_DEPTH;
    assign w_flush    = redirect && (state_q != S_IDLE);
    assign w_issue    = (state_q == S_RUN) && !redirect && w_space && in_range(pc_q, rom_size);
    assign w_push     = inflight_q && !w_flush;
    assign w_pop      = instr_valid && instr_ready && !w_flush;

    assign rom_req     = w_issue;
    assign rom_addr    = pc_q;
    assign instr_valid = (count_q != '0);
    assign instr       = data_mem_q[rd_ptr_q];
    assign instr_pc    = pc_mem_q[rd_ptr_q];
    assign busy        = busy_q;
    assign fetch_done  = done_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inflight_d = w_issue;
        count_d    = count_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    pc_d    = w_start_pc;
                    state_d = in_range(w_start_pc, rom_size) ? S_RUN : S_DRAIN;
                end
            end
            S_RUN: begin
                if (w_issue) begin
                    pc_d = w_pc_inc;
                    if (!in_range(w_pc_inc, rom_size)) begin
                        state_d = S_DRAIN;
                    end
                end else if (!in_range(pc_q, rom_size)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!inflight_q && (count_q == '0)) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (w_push && !w_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            count_d = count_q - CNT_W'(1);
        end

        // Redirect overrides everything: the in-flight response is dropped via w_push.
        if (w_flush) begin
            pc_d    = w_redir_pc;
            state_d = in_range(w_redir_pc, rom_size) ? S_RUN : S_DRAIN;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            inflight_q <= 1'b0;
            req_pc_q   <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                data_mem_q[i] <= '0;
                pc_mem_q[i]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            busy_q     <= (state_d == S_RUN) || (state_d == S_DRAIN);
            done_q     <= (state_d == S_DONE);

            if (w_issue) begin
                req_pc_q <= pc_q;
            end

            if (w_flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (w_push) begin
                    data_mem_q[wr_ptr_q] <= rom_data;
                    pc_mem_q[wr_ptr_q]   <= req_pc_q;
                    wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
                end
                if (w_pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Summary  : Program table, directed corner sequences and randomized runs
//            scored against a transaction-level fetch model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;

    logic        clk         = 1'b0;
    logic        reset       = 1'b1;
    logic        start       = 1'b0;
    logic [31:0] start_pc    = '0;
    logic [31:0] rom_size    = '0;
    logic        rom_req;
    logic [31:0] rom_addr;
    logic [31:0] rom_data    = '0;
    logic        redirect    = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        busy;
    logic        fetch_done;

    fetch_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_pc   (start_pc),
        .rom_size   (rom_size),
        .rom_req    (rom_req),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_ready(instr_ready),
        .busy       (busy),
        .fetch_done (fetch_done)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // ROM image: word i encodes "addi x(i%32), x0, i".
    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        logic [31:0] idx;
        idx = {22'd0, addr[9:2]};
        return (idx << 20) | ((idx & 32'd31) << 7) | 32'h13;
    endfunction

    function automatic logic fits(input logic [31:0] pc, input logic [31:0] size);
        return ({1'b0, pc} + 33'd4) <= {1'b0, size};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) rom_data <= rom_req ? rom_word(rom_addr) : 32'hBAD0BAD0;

    // Transaction-level model: expected issue and delivery address streams.
    logic [31:0] m_exp_pc  = '0;
    logic [31:0] m_iss_pc  = '0;
    int          m_out     = 0;
    bit          m_started = 1'b0;
    int          n_req     = 0;
    int          n_acc     = 0;
    bit          h_prev    = 1'b0;
    logic [31:0] h_instr   = '0;
    logic [31:0] h_pc      = '0;

    always @(negedge clk) begin
        if (!reset) begin
            m_started = 1'b0;
            m_out     = 0;
            h_prev    = 1'b0;
        end else begin
            if (h_prev) begin
                chk("hold_valid", instr_valid, 1);
                chk("hold_instr", instr, h_instr);
                chk("hold_pc", instr_pc, h_pc);
            end
            h_prev  = instr_valid && !instr_ready && !(redirect && m_started);
            h_instr = instr;
            h_pc    = instr_pc;
            if (redirect && m_started) begin
                chk("req_during_redirect", rom_req, 0);
                m_exp_pc = redirect_pc & ~32'd3;
                m_iss_pc = m_exp_pc;
                m_out    = 0;
            end else if (start) begin
                m_started = 1'b1;
                m_exp_pc  = start_pc & ~32'd3;
                m_iss_pc  = m_exp_pc;
                m_out     = 0;
            end else begin
                if (rom_req) begin
                    chk("req_addr", rom_addr, m_iss_pc);
                    chk("req_in_range", fits(m_iss_pc, rom_size), 1);
                    m_iss_pc += 4;
                    m_out++;
                    n_req++;
                end
                if (instr_valid && instr_ready) begin
                    chk("acc_pc", instr_pc, m_exp_pc);
                    chk("acc_instr", instr, rom_word(m_exp_pc));
                    m_exp_pc += 4;
                    m_out--;
                    n_acc++;
                end
                chk("occupancy", m_out <= DEPTH, 1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int max_cyc, output int lat);
        int c;
        lat = 0;
        c   = 0;
        while (lat == 0 && c < max_cyc) begin
            tick();
            c++;
            if (fetch_done) lat = c;
        end
        chk("done_reached", fetch_done, 1);
    endtask

    typedef struct {
        logic [31:0] sp;
        logic [31:0] size;
        int          words;
        int          first_lat;
        int          done_lat;
    } prog_t;

    prog_t progs[10];

    initial begin
        int lat, r0, a0, first, dlat, c;

        progs[0] = '{32'h0000_0000, 32'd16,        4, 2, 7};
        progs[1] = '{32'h0000_0000, 32'd10,        2, 2, 5};
        progs[2] = '{32'h0000_0400, 32'd1024,      0, 0, 1};
        progs[3] = '{32'h0000_0000, 32'd3,         0, 0, 1};
        progs[4] = '{32'h0000_0006, 32'd16,        3, 2, 6};
        progs[5] = '{32'h0000_03F8, 32'd1024,      2, 2, 5};
        progs[6] = '{32'hFFFF_FFF8, 32'hFFFF_FFFF, 1, 2, 4};
        progs[7] = '{32'hFFFF_FFFC, 32'hFFFF_FFFF, 0, 0, 1};
        progs[8] = '{32'h0000_0000, 32'd0,         0, 0, 1};
        progs[9] = '{32'h0000_0100, 32'h0000_010C, 3, 2, 6};

        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_rom_req", rom_req, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_instr", instr, 0);
        chk("rst_instr_pc", instr_pc, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", fetch_done, 0);
        tick();
        reset = 1'b1;
        tick();

        for (int v = 0; v < 10; v++) begin
            r0 = n_req;
            a0 = n_acc;
            start_pc    = progs[v].sp;
            rom_size    = progs[v].size;
            instr_ready = 1'b1;
            start       = 1'b1;
            tick();
            start = 1'b0;
            first = 0;
            dlat  = 0;
            for (int k = 1; k <= 64 && dlat == 0; k++) begin
                tick();
                if (instr_valid && first == 0) first = k;
                if (fetch_done) dlat = k;
            end
            chk("tbl_first_valid", first, progs[v].first_lat);
            chk("tbl_done_lat", dlat, progs[v].done_lat);
            chk("tbl_words", n_acc - a0, progs[v].words);
            chk("tbl_reqs", n_req - r0, progs[v].words);
            chk("tbl_all_delivered", fits(m_exp_pc, rom_size), 0);
            chk("tbl_busy_clear", busy, 0);
        end

        // Backpressure: FIFO fills, fetch stalls, then drains in order.
        r0 = n_req;
        a0 = n_acc;
        start_pc = 0; rom_size = 40; instr_ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        chk("bp_reqs", n_req - r0, 4);
        chk("bp_req_stalled", rom_req, 0);
        chk("bp_valid", instr_valid, 1);
        chk("bp_head_pc", instr_pc, 0);
        chk("bp_head_instr", instr, rom_word(0));
        instr_ready = 1'b1;
        wait_done(64, lat);
        chk("bp_words", n_acc - a0, 10);
        chk("bp_reqs_total", n_req - r0, 10);

        // Redirect while the read of 0x08 is in flight.
        r0 = n_req;
        start_pc = 0; rom_size = 64; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("rd_issued", n_req - r0, 3);
        chk("rd_head_pc", instr_pc, 4);
        redirect = 1'b1; redirect_pc = 32'h20;
        #1;
        chk("rd_no_req", rom_req, 0);
        tick();
        redirect = 1'b0;
        chk("rd_flushed", instr_valid, 0);
        c = 0;
        while (!instr_valid && c < 8) begin
            tick();
            c++;
        end
        chk("rd_next_pc", instr_pc, 32'h20);
        chk("rd_next_instr", instr, rom_word(32'h20));
        wait_done(64, lat);

        // Restart from DONE through a redirect.
        a0 = n_acc;
        rom_size = 16; redirect_pc = 4; redirect = 1'b1;
        tick();
        redirect = 1'b0;
        chk("rs_busy", busy, 1);
        chk("rs_done_clear", fetch_done, 0);
        wait_done(64, lat);
        chk("rs_words", n_acc - a0, 3);
        chk("rs_end_pc", m_exp_pc, 16);

        // start and redirect together in DONE: redirect target wins.
        a0 = n_acc;
        rom_size = 64; start_pc = 0; redirect_pc = 32'h30;
        start = 1'b1; redirect = 1'b1;
        tick();
        start = 1'b0; redirect = 1'b0;
        wait_done(64, lat);
        chk("sr_words", n_acc - a0, 4);

        // Out-of-range redirect goes straight through DRAIN to DONE.
        r0 = n_req;
        redirect_pc = 32'h40; redirect = 1'b1;
        tick();
        redirect = 1'b0;
        chk("oor_not_done", fetch_done, 0);
        wait_done(8, lat);
        chk("oor_done_lat", lat, 1);
        chk("oor_no_req", n_req - r0, 0);

        // Asynchronous reset with three words buffered.
        start_pc = 0; rom_size = 64; instr_ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("ar_filled", instr_valid, 1);
        #1 reset = 1'b0;
        #1;
        chk("ar_valid", instr_valid, 0);
        chk("ar_req", rom_req, 0);
        chk("ar_busy", busy, 0);
        chk("ar_done", fetch_done, 0);
        chk("ar_instr_pc", instr_pc, 0);
        chk("ar_rom_addr", rom_addr, 0);
        tick();
        tick();
        reset = 1'b1;
        instr_ready = 1'b1;
        repeat (6) begin
            tick();
            chk("ar_quiet_valid", instr_valid, 0);
            chk("ar_quiet_req", rom_req, 0);
        end

        // Randomized programs, backpressure and redirects.
        for (int it = 0; it < 40; it++) begin
            rom_size = $urandom_range(0, 96);
            start_pc = $urandom_range(0, 104);
            start    = 1'b1;
            if ($urandom_range(0, 3) == 0) begin
                redirect    = 1'b1;
                redirect_pc = $urandom_range(0, 100);
            end
            tick();
            start    = 1'b0;
            redirect = 1'b0;
            for (int k = 0; k < 60; k++) begin
                instr_ready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 15) == 0) begin
                    redirect    = 1'b1;
                    redirect_pc = $urandom_range(0, 100);
                end
                tick();
                redirect = 1'b0;
            end
            instr_ready = 1'b1;
            wait_done(200, lat);
            chk("rnd_all_delivered", fits(m_exp_pc, rom_size), 0);
            chk("rnd_drained", instr_valid, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1);
    end

endmodule
`default_nettype wire
